// File: rtl/fp_pkg.sv
// Shared types and encoding helpers for the parametrised floating-point add/subtract unit.
// Encoding helpers return a wide vector; callers cast down to their own word width.
package fp_pkg;

    typedef enum logic [2:0] {
        IDLE,
        UNPACK,
        ALIGN,
        ADD,
        NORM,
        ROUND,
        DONE
    } fp_state_t;

    localparam logic RND_RNE   = 1'b0;
    localparam logic RND_TRUNC = 1'b1;

    localparam int FP_MAX_W = 128;

    function automatic int fp_bias(input int exp_w);
        return (1 << (exp_w - 1)) - 1;
    endfunction

    function automatic logic [FP_MAX_W-1:0] fp_inf(input int exp_w, input int man_w);
        logic [FP_MAX_W-1:0] v;
        v = '0;
        for (int i = 0; i < exp_w; i++) v[man_w+i] = 1'b1;
        return v;
    endfunction

    function automatic logic [FP_MAX_W-1:0] fp_qnan(input int exp_w, input int man_w);
        logic [FP_MAX_W-1:0] v;
        v = fp_inf(exp_w, man_w);
        v[man_w-1] = 1'b1;
        return v;
    endfunction

    // Largest finite magnitude: exponent all-ones minus one, fraction all ones.
    function automatic logic [FP_MAX_W-1:0] fp_max_finite(input int exp_w, input int man_w);
        logic [FP_MAX_W-1:0] v;
        v = fp_inf(exp_w, man_w);
        v[man_w] = 1'b0;
        for (int i = 0; i < man_w; i++) v[i] = 1'b1;
        return v;
    endfunction

endpackage

// File: rtl/fp_addsub_seq_lzc.sv
// Combinational leading-zero counter used to renormalise the significand after subtraction.
// An all-zero input reports WIDTH.
module fp_lzc #(
    parameter int WIDTH = 27,
    localparam int CW = $clog2(WIDTH + 1)
) (
    input  logic [WIDTH-1:0] value,
    output logic [CW-1:0]    count
);

    // Ascending scan so the highest set bit is the last one to update the count.
    always_comb begin
        count = CW'(WIDTH);
        for (int i = 0; i < WIDTH; i++) begin
            if (value[i]) count = CW'(WIDTH - 1 - i);
        end
    end

endmodule

// File: rtl/fp_addsub_seq.sv
// Multi-cycle IEEE-754 style adder/subtractor with FTZ inputs, RNE/truncate rounding,
// special-value handling and exception flags, using a load/ready handshake with clock enable.
module fp_addsub_seq
    import fp_pkg::*;
#(
    parameter int EXP_W = 8,
    parameter int MAN_W = 23,
    localparam int W = EXP_W + MAN_W + 1
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         en,
    input  logic         load,
    input  logic         op,
    input  logic         rnd_mode,
    input  logic [W-1:0] a,
    input  logic [W-1:0] b,
    output logic [W-1:0] result,
    output logic         ready,
    output logic         flag_ovf,
    output logic         flag_unf,
    output logic         flag_inv,
    output logic         flag_inx
);

    localparam int SW        = MAN_W + 1;
    localparam int XW        = MAN_W + 4;
    localparam int EW        = EXP_W + 2;
    localparam int CW        = $clog2(XW + 1);
    localparam int SHIFT_MAX = MAN_W + 3;

    localparam logic [EXP_W-1:0]    EXP_ONES  = '1;
    localparam logic [W-1:0]        QNAN      = W'(fp_qnan(EXP_W, MAN_W));
    localparam logic [W-1:0]        INF       = W'(fp_inf(EXP_W, MAN_W));
    localparam logic [W-1:0]        MAX_FIN   = W'(fp_max_finite(EXP_W, MAN_W));
    localparam logic signed [EW-1:0] EXP_LIMIT = $signed({2'b00, EXP_ONES});
    localparam logic signed [EW-1:0] EXP_ZERO  = '0;
    localparam logic signed [EW-1:0] EXP_INC   = EW'(1);

    fp_state_t state, state_next;

    logic [W-1:0]            a_reg, b_reg;
    logic                    op_reg, rnd_reg;
    logic                    sign_a, sign_b;
    logic [EXP_W-1:0]        exp_a, exp_b;
    logic [SW-1:0]           sig_a, sig_b;
    logic                    sign_x, sign_y;
    logic [EXP_W-1:0]        exp_x;
    logic [XW-1:0]           big_sig, small_sig;
    logic [XW:0]             sum;
    logic                    sign_n;
    logic signed [EW-1:0]    exp_n;
    logic [XW-1:0]           norm_sig;

    logic                    ua_sign, ub_sign;
    logic [EXP_W-1:0]        ua_exp, ub_exp;
    logic [MAN_W-1:0]        ua_frac, ub_frac;
    logic                    a_nan, b_nan, a_inf, b_inf;
    logic                    spec_hit, spec_inv;
    logic [W-1:0]            spec_res;

    logic                    a_ge, sign_x_d, sign_y_d;
    logic [EXP_W-1:0]        exp_x_d, exp_y_d;
    logic [SW-1:0]           sig_x_d, sig_y_d;
    logic [31:0]             diff, shamt;
    logic [SW+SHIFT_MAX-1:0] ext, shifted;
    logic [XW-1:0]           small_d;

    logic [XW:0]             sum_d;
    logic [CW-1:0]           lz;
    logic                    sum_zero;
    logic [XW-1:0]           norm_d;
    logic signed [EW-1:0]    exp_norm_d;

    logic [SW-1:0]           mant;
    logic                    g, r, s, inc;
    logic [SW:0]             rounded;
    logic signed [EW-1:0]    exp_r;
    logic [MAN_W-1:0]        frac_r;
    logic                    r_ovf, r_unf, r_inx;
    logic [W-1:0]            r_res;

    assign ready = (state == IDLE) || (state == DONE);

    assign ua_sign = a_reg[W-1];
    assign ua_exp  = a_reg[W-2:MAN_W];
    assign ua_frac = a_reg[MAN_W-1:0];
    assign ub_sign = b_reg[W-1] ^ op_reg;
    assign ub_exp  = b_reg[W-2:MAN_W];
    assign ub_frac = b_reg[MAN_W-1:0];

    assign a_nan = (ua_exp == EXP_ONES) && (ua_frac != '0);
    assign b_nan = (ub_exp == EXP_ONES) && (ub_frac != '0);
    assign a_inf = (ua_exp == EXP_ONES) && (ua_frac == '0);
    assign b_inf = (ub_exp == EXP_ONES) && (ub_frac == '0);

    always_comb begin
        spec_hit = 1'b0;
        spec_inv = 1'b0;
        spec_res = '0;
        if (a_nan || b_nan || (a_inf && b_inf && (ua_sign != ub_sign))) begin
            spec_hit = 1'b1;
            spec_inv = 1'b1;
            spec_res = QNAN;
        end else if (a_inf) begin
            spec_hit = 1'b1;
            spec_res = {ua_sign, INF[W-2:0]};
        end else if (b_inf) begin
            spec_hit = 1'b1;
            spec_res = {ub_sign, INF[W-2:0]};
        end
    end

    // Order operands by magnitude so the subtraction never goes negative.
    always_comb begin
        a_ge = {exp_a, sig_a} >= {exp_b, sig_b};
        if (a_ge) begin
            sign_x_d = sign_a; exp_x_d = exp_a; sig_x_d = sig_a;
            sign_y_d = sign_b; exp_y_d = exp_b; sig_y_d = sig_b;
        end else begin
            sign_x_d = sign_b; exp_x_d = exp_b; sig_x_d = sig_b;
            sign_y_d = sign_a; exp_y_d = exp_a; sig_y_d = sig_a;
        end
        diff    = 32'(exp_x_d) - 32'(exp_y_d);
        shamt   = (diff >= 32'(SHIFT_MAX)) ? 32'(SHIFT_MAX) : diff;
        ext     = {sig_y_d, {SHIFT_MAX{1'b0}}};
        shifted = ext >> shamt;
        small_d = {shifted[SW+SHIFT_MAX-1:SW], |shifted[SW-1:0]};
    end

    assign sum_d = (sign_x ^ sign_y) ? ({1'b0, big_sig} - {1'b0, small_sig})
                                     : ({1'b0, big_sig} + {1'b0, small_sig});

    fp_lzc #(.WIDTH(XW)) u_lzc (
        .value (sum[XW-1:0]),
        .count (lz)
    );

    always_comb begin
        sum_zero = (sum == '0);
        if (sum[XW]) begin
            norm_d     = {sum[XW:2], sum[1] | sum[0]};
            exp_norm_d = $signed({2'b00, exp_x}) + EXP_INC;
        end else begin
            norm_d     = sum[XW-1:0] << lz;
            exp_norm_d = $signed({2'b00, exp_x}) - $signed({{(EW-CW){1'b0}}, lz});
        end
    end

    // Layout of norm_sig: hidden bit and fraction on top, then guard, round, sticky.
    always_comb begin
        mant    = norm_sig[XW-1:3];
        g       = norm_sig[2];
        r       = norm_sig[1];
        s       = norm_sig[0];
        inc     = (rnd_reg == RND_RNE) && g && (r || s || mant[0]);
        rounded = {1'b0, mant} + {{SW{1'b0}}, inc};
        if (rounded[SW]) begin
            exp_r  = exp_n + EXP_INC;
            frac_r = rounded[MAN_W:1];
        end else begin
            exp_r  = exp_n;
            frac_r = rounded[MAN_W-1:0];
        end
        r_ovf = 1'b0;
        r_unf = 1'b0;
        r_inx = g | r | s;
        r_res = {sign_n, exp_r[EXP_W-1:0], frac_r};
        if (exp_n <= EXP_ZERO) begin
            r_unf = 1'b1;
            r_inx = 1'b1;
            r_res = {sign_n, {(W-1){1'b0}}};
        end else if (exp_r >= EXP_LIMIT) begin
            r_ovf = 1'b1;
            r_inx = 1'b1;
            r_res = (rnd_reg == RND_TRUNC) ? {sign_n, MAX_FIN[W-2:0]} : {sign_n, INF[W-2:0]};
        end
    end

    always_comb begin
        state_next = state;
        case (state)
            IDLE, DONE: if (load) state_next = UNPACK;
            UNPACK:     state_next = spec_hit ? DONE : ALIGN;
            ALIGN:      state_next = ADD;
            ADD:        state_next = NORM;
            NORM:       state_next = sum_zero ? DONE : ROUND;
            ROUND:      state_next = DONE;
            default:    state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= IDLE;
        else if (en) state <= state_next;
    end

    // The result register is written only on entry to DONE, so aborted work never shows.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            a_reg <= '0; b_reg <= '0; op_reg <= 1'b0; rnd_reg <= 1'b0;
            sign_a <= 1'b0; sign_b <= 1'b0; exp_a <= '0; exp_b <= '0; sig_a <= '0; sig_b <= '0;
            sign_x <= 1'b0; sign_y <= 1'b0; exp_x <= '0; big_sig <= '0; small_sig <= '0;
            sum <= '0; sign_n <= 1'b0; exp_n <= '0; norm_sig <= '0;
            result <= '0;
            flag_ovf <= 1'b0; flag_unf <= 1'b0; flag_inv <= 1'b0; flag_inx <= 1'b0;
        end else if (en) begin
            case (state)
                IDLE, DONE: begin
                    if (load) begin
                        a_reg    <= a;
                        b_reg    <= b;
                        op_reg   <= op;
                        rnd_reg  <= rnd_mode;
                        flag_ovf <= 1'b0;
                        flag_unf <= 1'b0;
                        flag_inv <= 1'b0;
                        flag_inx <= 1'b0;
                    end
                end
                UNPACK: begin
                    if (spec_hit) begin
                        result   <= spec_res;
                        flag_inv <= spec_inv;
                    end else begin
                        sign_a <= ua_sign;
                        sign_b <= ub_sign;
                        exp_a  <= ua_exp;
                        exp_b  <= ub_exp;
                        sig_a  <= (ua_exp != '0) ? {1'b1, ua_frac} : '0;
                        sig_b  <= (ub_exp != '0) ? {1'b1, ub_frac} : '0;
                    end
                end
                ALIGN: begin
                    sign_x    <= sign_x_d;
                    sign_y    <= sign_y_d;
                    exp_x     <= exp_x_d;
                    big_sig   <= {sig_x_d, 3'b000};
                    small_sig <= small_d;
                end
                ADD: sum <= sum_d;
                NORM: begin
                    if (sum_zero) begin
                        result <= '0;
                    end else begin
                        norm_sig <= norm_d;
                        exp_n    <= exp_norm_d;
                        sign_n   <= sign_x;
                    end
                end
                ROUND: begin
                    result   <= r_res;
                    flag_ovf <= r_ovf;
                    flag_unf <= r_unf;
                    flag_inx <= r_inx;
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_fp_addsub_seq.sv
// Directed self-checking bench for fp_addsub_seq: single precision vectors, stall, reset abort,
// and one double precision sum on a second instance.
module tb_fp_addsub_seq;

    logic        clk, rst, en;
    logic        load, op, rnd_mode;
    logic [31:0] a, b, result;
    logic        ready, flag_ovf, flag_unf, flag_inv, flag_inx;

    logic        load_d, op_d, rnd_d;
    logic [63:0] a_d, b_d, result_d;
    logic        ready_d, ovf_d, unf_d, inv_d, inx_d;

    int tests = 0;
    int fails = 0;

    typedef struct {
        logic [31:0] a;
        logic [31:0] b;
        logic        op;
        logic        rnd;
        logic [31:0] res;
        logic [3:0]  fl;
        int          cyc;
        int          stall;
    } vec_t;

    vec_t vecs[14];

    fp_addsub_seq dut (
        .clk(clk), .rst(rst), .en(en), .load(load), .op(op), .rnd_mode(rnd_mode),
        .a(a), .b(b), .result(result), .ready(ready),
        .flag_ovf(flag_ovf), .flag_unf(flag_unf), .flag_inv(flag_inv), .flag_inx(flag_inx)
    );

    fp_addsub_seq #(.EXP_W(11), .MAN_W(52)) dut_d (
        .clk(clk), .rst(rst), .en(1'b1), .load(load_d), .op(op_d), .rnd_mode(rnd_d),
        .a(a_d), .b(b_d), .result(result_d), .ready(ready_d),
        .flag_ovf(ovf_d), .flag_unf(unf_d), .flag_inv(inv_d), .flag_inx(inx_d)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic checkOutput(input string tag, input logic [63:0] actual, input logic [63:0] expected);
        tests++;
        if (actual !== expected) begin
            fails++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, actual, expected);
        end
    endtask

    // Cycles are counted on falling edges after the accepting rising edge.
    task automatic applyStimulus(input logic dbl, input logic [63:0] av, input logic [63:0] bv,
                                 input logic opv, input logic rv, input int stall_start,
                                 output int cycles);
        logic rdy;
        @(negedge clk);
        if (dbl) begin
            a_d = av; b_d = bv; op_d = opv; rnd_d = rv; load_d = 1'b1;
        end else begin
            a = av[31:0]; b = bv[31:0]; op = opv; rnd_mode = rv; load = 1'b1;
        end
        cycles = 0;
        rdy = 1'b0;
        @(posedge clk);
        for (int i = 0; i < 50; i++) begin
            @(negedge clk);
            load = 1'b0;
            load_d = 1'b0;
            cycles++;
            rdy = dbl ? ready_d : ready;
            if (rdy) break;
            en = !(stall_start > 0 && cycles >= stall_start && cycles < stall_start + 3);
        end
        en = 1'b1;
        if (!rdy) checkOutput("timeout_ready", 64'(rdy), 64'd1);
    endtask

    initial begin
        int cyc;
        rst = 1'b1; en = 1'b1; load = 1'b0; op = 1'b0; rnd_mode = 1'b0; a = '0; b = '0;
        load_d = 1'b0; op_d = 1'b0; rnd_d = 1'b0; a_d = '0; b_d = '0;

        #12;
        checkOutput("reset_result", 64'(result), 64'd0);
        checkOutput("reset_ready", 64'(ready), 64'd1);
        checkOutput("reset_flags", 64'({flag_ovf, flag_unf, flag_inv, flag_inx}), 64'd0);
        checkOutput("reset_ready_dbl", 64'(ready_d), 64'd1);
        @(negedge clk);
        rst = 1'b0;

        // flags are {ovf, unf, inv, inx}
        vecs[0]  = '{32'h40D80000, 32'h40400000, 1'b0, 1'b0, 32'h411C0000, 4'b0000, 6, 0};
        vecs[1]  = '{32'h4B800000, 32'h40400000, 1'b0, 1'b0, 32'h4B800002, 4'b0001, 6, 0};
        vecs[2]  = '{32'h4B800000, 32'h40400000, 1'b0, 1'b1, 32'h4B800001, 4'b0001, 6, 0};
        vecs[3]  = '{32'h3F800000, 32'h3F800000, 1'b1, 1'b0, 32'h00000000, 4'b0000, 5, 0};
        vecs[4]  = '{32'h7F7FFFFF, 32'h7F7FFFFF, 1'b0, 1'b0, 32'h7F800000, 4'b1001, 6, 0};
        vecs[5]  = '{32'h7F7FFFFF, 32'h7F7FFFFF, 1'b0, 1'b1, 32'h7F7FFFFF, 4'b1001, 6, 0};
        vecs[6]  = '{32'h7F800000, 32'hFF800000, 1'b0, 1'b0, 32'h7FC00000, 4'b0010, 2, 0};
        vecs[7]  = '{32'h4B000000, 32'h3F800000, 1'b0, 1'b0, 32'h4B000001, 4'b0000, 6, 0};
        vecs[8]  = '{32'h40400000, 32'h40D80000, 1'b1, 1'b0, 32'hC0700000, 4'b0000, 6, 0};
        vecs[9]  = '{32'h7FC00001, 32'h3F800000, 1'b0, 1'b0, 32'h7FC00000, 4'b0010, 2, 0};
        vecs[10] = '{32'h3F800000, 32'h7F800000, 1'b1, 1'b0, 32'hFF800000, 4'b0000, 2, 0};
        vecs[11] = '{32'h00800001, 32'h00800000, 1'b1, 1'b0, 32'h00000000, 4'b0101, 6, 0};
        vecs[12] = '{32'h00000001, 32'h3F800000, 1'b0, 1'b0, 32'h3F800000, 4'b0000, 6, 0};
        vecs[13] = '{32'h40D80000, 32'h40400000, 1'b0, 1'b0, 32'h411C0000, 4'b0000, 9, 2};

        for (int i = 0; i < 14; i++) begin
            applyStimulus(1'b0, 64'(vecs[i].a), 64'(vecs[i].b), vecs[i].op, vecs[i].rnd,
                          vecs[i].stall, cyc);
            checkOutput($sformatf("v%0d_result", i), 64'(result), 64'(vecs[i].res));
            checkOutput($sformatf("v%0d_flags", i),
                        64'({flag_ovf, flag_unf, flag_inv, flag_inx}), 64'(vecs[i].fl));
            checkOutput($sformatf("v%0d_latency", i), 64'(cyc), 64'(vecs[i].cyc));
        end

        // Abort an operation in ALIGN; reset must act without waiting for a clock edge.
        @(negedge clk);
        a = 32'h3F800000; b = 32'h3F800000; op = 1'b0; rnd_mode = 1'b0; load = 1'b1;
        @(negedge clk);
        load = 1'b0;
        @(negedge clk);
        checkOutput("align_busy", 64'(ready), 64'd0);
        rst = 1'b1;
        #1;
        checkOutput("abort_ready", 64'(ready), 64'd1);
        checkOutput("abort_result", 64'(result), 64'd0);
        checkOutput("abort_flags", 64'({flag_ovf, flag_unf, flag_inv, flag_inx}), 64'd0);
        @(negedge clk);
        rst = 1'b0;

        applyStimulus(1'b1, 64'h3FF0000000000000, 64'h3FF0000000000000, 1'b0, 1'b0, 0, cyc);
        checkOutput("dbl_result", result_d, 64'h4000000000000000);
        checkOutput("dbl_flags", 64'({ovf_d, unf_d, inv_d, inx_d}), 64'd0);
        checkOutput("dbl_latency", 64'(cyc), 64'd6);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
